// File: rtl/obsm.sv
// obsm: output-port arbiter for a wormhole router. Picks one input port whose
// FIFO head is a HEAD flit (round-robin after the last served port), then holds
// the output for that port until its TAIL flit has been popped.
//
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - asynchronous active-low reset
//   reqv  - per-input request for this output port
//   flow  - per-input head-of-FIFO flit type, port i at [2i+1:2i]
//   full  - output FIFO full
//   ack   - one-hot pop grant to the owning input (combinational)
//   sel   - crossbar select, index of the owning input
//   we    - output FIFO write enable, ack delayed one cycle
//   busy  - a packet currently owns the output
module obsm #(
    parameter int unsigned NPORT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORT-1:0]     reqv,
    input  logic [2*NPORT-1:0]   flow,
    input  logic                 full,
    output logic [NPORT-1:0]     ack,
    output logic [1:0]           sel,
    output logic                 we,
    output logic                 busy
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    // Flit type encodings; BODY (2'b10) needs no special handling here.
    localparam logic [1:0] EMPT = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b11;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [NPORT-1:0] grant, grant_nxt;
    logic [PW-1:0]    gidx, gidx_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;

    logic [1:0]       flow_a [NPORT];
    logic [NPORT-1:0] elig;
    logic [1:0]       flow_g;
    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    int unsigned      idx;

    // Unpack flow into per-port types and find HEAD-ready requesters.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            flow_a[i] = flow[2*i +: 2];
            elig[i]   = reqv[i] && (flow[2*i +: 2] == HEAD);
        end
    end

    assign flow_g = flow_a[gidx];

    // Round-robin pick starting at ptr+1; scanning far-to-near lets the
    // nearest eligible port overwrite earlier candidates.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int unsigned k = NPORT; k >= 1; k--) begin
            idx = (32'(ptr) + k) % NPORT;
            if (elig[PW'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    // Pop grant: only the owner, only when a flit is present and space exists.
    always_comb begin
        ack = '0;
        if ((state == BUSY) && !full && (flow_g != EMPT)) begin
            ack = grant;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                    grant_nxt = NPORT'(1) << pick_idx;
                    gidx_nxt  = pick_idx;
                end
            end
            BUSY: begin
                if ((|ack) && (flow_g == TAIL)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gidx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; we tracks ack one cycle late to match the input FIFO read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= PW'(NPORT - 1);
            we    <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
            we    <= |ack;
        end
    end

    assign sel  = 2'(gidx);
    assign busy = (state == BUSY);

endmodule

// File: tb/tb_obsm.sv
// tb_obsm: directed vector table, hand-written corner sequences, and a
// randomized run against a packet-level reference model of the arbiter.
module tb_obsm;

    localparam int N = 4;
    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;
    localparam logic [1:0] T = 2'b11;

    logic         clk;
    logic         rst;
    logic [3:0]   reqv;
    logic [7:0]   flow;
    logic         full;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic         we;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    obsm #(.NPORT(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .reqv (reqv),
        .flow (flow),
        .full (full),
        .ack  (ack),
        .sel  (sel),
        .we   (we),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] reqv;
        logic [7:0] flow;
        logic       full;
        logic [3:0] ack;
        logic       we;
        logic       busy;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [7:0] fl(input logic [1:0] f0, input logic [1:0] f1,
                                      input logic [1:0] f2, input logic [1:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    function automatic vec_t v(input logic [3:0] r, input logic [7:0] f, input logic fu,
                               input logic [3:0] a, input logic w, input logic bz,
                               input logic [1:0] s);
        vec_t x;
        x.reqv = r; x.flow = f; x.full = fu;
        x.ack = a; x.we = w; x.busy = bz; x.sel = s;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [3:0] r, input logic [7:0] f, input logic fu);
        reqv = r;
        flow = f;
        full = fu;
    endtask

    // Packet-level reference state for the random run.
    int         left [N];
    int         pidx [N];
    logic [1:0] ft   [N];
    logic       rq   [N];

    initial begin
        logic [3:0] exp_ack;
        logic       m_busy;
        int         m_port, m_ptr, m_sel;
        logic       prev_ack_any;
        int         ack_cnt, we_cnt;
        int         pos [N];
        int         order [$];
        logic       prev_busy;
        logic [7:0] fv;
        logic [3:0] rv;
        logic       fu;
        logic [1:0] popped;
        bit         done;

        // Directed vectors: one row per cycle, inputs then sampled outputs.
        tbl[0]  = v(4'b0001, fl(H,E,E,E), 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        tbl[1]  = v(4'b0001, fl(H,E,E,E), 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0);
        tbl[2]  = v(4'b0001, fl(B,E,E,E), 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0);
        tbl[3]  = v(4'b0001, fl(T,E,E,E), 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0);
        tbl[4]  = v(4'b0000, fl(E,E,E,E), 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        tbl[5]  = v(4'b0000, fl(E,E,E,E), 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        tbl[6]  = v(4'b0100, fl(E,E,B,E), 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        tbl[7]  = v(4'b0100, fl(E,E,H,E), 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        tbl[8]  = v(4'b0100, fl(E,E,H,E), 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        tbl[9]  = v(4'b0100, fl(E,E,B,E), 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2);
        tbl[10] = v(4'b0100, fl(E,E,E,E), 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2);
        tbl[11] = v(4'b1111, fl(H,H,E,H), 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2);
        tbl[12] = v(4'b0100, fl(E,E,B,E), 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        tbl[13] = v(4'b0100, fl(E,E,T,E), 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2);
        tbl[14] = v(4'b0100, fl(E,E,T,E), 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
        tbl[15] = v(4'b0100, fl(E,E,T,E), 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
        tbl[16] = v(4'b0100, fl(E,E,T,E), 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
        tbl[17] = v(4'b0000, fl(E,E,E,E), 1'b0, 4'b0000, 1'b1, 1'b0, 2'd2);
        tbl[18] = v(4'b0000, fl(E,E,E,E), 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2);
        tbl[19] = v(4'b1000, fl(E,E,E,H), 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2);
        tbl[20] = v(4'b1000, fl(E,E,E,H), 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3);
        tbl[21] = v(4'b1000, fl(E,E,E,H), 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3);
        tbl[22] = v(4'b1000, fl(E,E,E,T), 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3);
        tbl[23] = v(4'b0000, fl(E,E,E,E), 1'b0, 4'b0000, 1'b1, 1'b0, 2'd3);

        // Reset values.
        rst = 1'b0;
        drive(4'b0000, 8'h00, 1'b0);
        #1;
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset we", 32'(we), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int r = 0; r < 24; r++) begin
            @(negedge clk);
            drive(tbl[r].reqv, tbl[r].flow, tbl[r].full);
            #1;
            chk($sformatf("row%0d ack", r), 32'(ack), 32'(tbl[r].ack));
            chk($sformatf("row%0d we", r), 32'(we), 32'(tbl[r].we));
            chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("row%0d sel", r), 32'(sel), 32'(tbl[r].sel));
        end

        // Four-way HEAD contest, two-flit packets: each port served once, in order 0..3.
        for (int i = 0; i < N; i++) pos[i] = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            rv = '0;
            fv = '0;
            for (int i = 0; i < N; i++) begin
                rv[i] = (pos[i] < 2);
                fv[2*i +: 2] = (pos[i] == 0) ? H : (pos[i] == 1) ? T : E;
            end
            drive(rv, fv, 1'b0);
            #1;
            if (busy && !prev_busy) order.push_back(int'(sel));
            for (int i = 0; i < N; i++) if (ack[i]) pos[i]++;
            prev_busy = busy;
            done = 1'b1;
            for (int i = 0; i < N; i++) if (pos[i] < 2) done = 1'b0;
            if (done) break;
        end
        chk("rr grant count", 32'(order.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr grant %0d", k), (k < order.size()) ? 32'(order[k]) : 32'hffff_ffff, 32'(k));
        end

        // Reset mid-packet: after port 0 then port 1 own the output, reset must restore priority.
        @(negedge clk); drive(4'b0001, fl(H,E,E,E), 1'b0);
        @(negedge clk); drive(4'b0001, fl(H,E,E,E), 1'b0); #1;
        chk("p0 ack", 32'(ack), 32'b0001);
        @(negedge clk); drive(4'b0001, fl(T,E,E,E), 1'b0);
        @(negedge clk); drive(4'b1111, fl(H,H,H,H), 1'b0);
        @(negedge clk); drive(4'b1111, fl(H,H,H,H), 1'b0); #1;
        chk("contest busy", 32'(busy), 32'd1);
        chk("contest sel", 32'(sel), 32'd1);
        chk("contest ack", 32'(ack), 32'b0010);
        @(negedge clk); drive(4'b1111, fl(H,B,H,H), 1'b0); #1;
        chk("pre-rst ack", 32'(ack), 32'b0010);
        chk("pre-rst we", 32'(we), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async rst ack", 32'(ack), 32'd0);
        chk("async rst we", 32'(we), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst sel", 32'(sel), 32'd0);
        @(negedge clk); rst = 1'b1; drive(4'b1111, fl(H,H,H,H), 1'b0); #1;
        chk("post-rst idle", 32'(busy), 32'd0);
        @(negedge clk); drive(4'b1111, fl(H,H,H,H), 1'b0); #1;
        chk("post-rst busy", 32'(busy), 32'd1);
        chk("post-rst sel", 32'(sel), 32'd0);
        chk("post-rst ack", 32'(ack), 32'b0001);

        // Randomized run against the reference model.
        @(negedge clk); rst = 1'b0; drive(4'b0000, 8'h00, 1'b0);
        @(negedge clk); rst = 1'b1;
        m_busy = 1'b0; m_port = 0; m_ptr = N - 1; m_sel = 0;
        prev_ack_any = 1'b0; ack_cnt = 0; we_cnt = 0;
        for (int i = 0; i < N; i++) begin left[i] = 0; pidx[i] = 0; end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rv = '0;
            fv = '0;
            for (int i = 0; i < N; i++) begin
                if (left[i] == 0 && ($urandom % 3) == 0) begin
                    left[i] = 2 + int'($urandom % 4);
                    pidx[i] = 0;
                end
                if (left[i] == 0 || ($urandom % 4) == 0) ft[i] = E;
                else if (pidx[i] == 0) ft[i] = H;
                else if (left[i] == 1) ft[i] = T;
                else ft[i] = B;
                rq[i] = (left[i] > 0) && (($urandom % 8) != 0);
                rv[i] = rq[i];
                fv[2*i +: 2] = ft[i];
            end
            fu = (($urandom % 5) == 0);
            drive(rv, fv, fu);
            #1;

            exp_ack = '0;
            if (m_busy && !fu && ft[m_port] != E) exp_ack[m_port] = 1'b1;
            chk("rnd ack", 32'(ack), 32'(exp_ack));
            chk("rnd we", 32'(we), 32'(prev_ack_any));
            chk("rnd busy", 32'(busy), 32'(m_busy));
            chk("rnd sel", 32'(sel), 32'(m_sel));
            if (we) we_cnt++;

            prev_ack_any = |exp_ack;
            if (m_busy) begin
                if (|exp_ack) begin
                    ack_cnt++;
                    popped = ft[m_port];
                    left[m_port]--;
                    pidx[m_port]++;
                    if (popped == T) begin
                        m_busy = 1'b0;
                        m_ptr  = m_port;
                    end
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int p;
                    p = (m_ptr + k) % N;
                    if (!m_busy && rq[p] && ft[p] == H) begin
                        m_busy = 1'b1;
                        m_port = p;
                        m_sel  = p;
                    end
                end
            end
        end
        chk("rnd flit count", 32'(we_cnt), 32'(ack_cnt - int'(prev_ack_any)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
